// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI op encodings, master FSM states and default bus widths.
`default_nettype none

package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmi_timeout_ctr.sv
// dmi_timeout_ctr: saturating cycle counter that flags expiry at TIMEOUT_CYCLES-1.
`default_nettype none

module dmi_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Saturation keeps expiry asserted if the count runs past LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

`default_nettype wire

// File: rtl/dmi_cmd_master.sv
// dmi_cmd_master: single-outstanding DMI request master with timeout and
// stale-response accounting.
`default_nettype none

module dmi_cmd_master
  import dmi_pkg::*;
#(
  parameter int ADDR_W         = DMI_ADDR_W,
  parameter int DATA_W         = DMI_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              rsp_error,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [1:0]        dmi_req_bits_op,
  output logic [ADDR_W-1:0] dmi_req_bits_addr,
  output logic [DATA_W-1:0] dmi_req_bits_data,
  input  logic              dmi_resp_valid,
  input  logic [DATA_W-1:0] dmi_resp_bits_data,
  output logic [7:0]        stale_resp_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tout_q, tout_d;
  logic              err_q, err_d;
  logic [7:0]        stale_q, stale_d;
  logic              busy;
  logic              expired;

  assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

  dmi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (!busy),
    .en_i     (busy),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tout_d  = tout_q;
    err_d   = err_q;
    stale_d = stale_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
          rdata_d = '0;
          tout_d  = 1'b0;
          err_d   = 1'b0;
          if ((cmd_op == OP_READ) || (cmd_op == OP_WRITE)) begin
            state_d = ST_REQ;
          end else begin
            err_d   = (cmd_op == OP_RSVD);
            state_d = ST_RESP;
          end
        end
      end
      // A handshake on the expiry cycle still wins; WAIT then times out next.
      ST_REQ: begin
        if (dmi_req_ready) begin
          state_d = ST_WAIT;
        end else if (expired) begin
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (dmi_resp_valid) begin
          rdata_d = dmi_resp_bits_data;
          state_d = ST_RESP;
        end else if (expired) begin
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dmi_resp_valid && (state_q != ST_WAIT) && (stale_q != 8'hFF)) begin
      stale_d = stale_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
      stale_q <= stale_d;
    end
  end

  assign cmd_ready         = (state_q == ST_IDLE) && reset;
  assign dmi_req_valid     = (state_q == ST_REQ);
  assign rsp_valid         = (state_q == ST_RESP);
  assign rsp_data          = rdata_q;
  assign rsp_timeout       = tout_q;
  assign rsp_error         = err_q;
  assign dmi_req_bits_op   = op_q;
  assign dmi_req_bits_addr = addr_q;
  assign dmi_req_bits_data = wdata_q;
  assign stale_resp_cnt    = stale_q;

endmodule

`default_nettype wire
